// File: rtl/fir_err_monitor.sv
// fir_err_monitor: gathers error statistics between an approximate and an
// accurate FIR output stream over a run of n_samples accepted sample pairs.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   clear             synchronous abort: returns to idle and zeroes everything
//   start, n_samples  begin a run of n_samples pairs (ignored while busy)
//   in_valid/in_ready pair handshake; appr/accu are the signed sample pair
//   busy, done        run active / run complete with stable statistics
//   cnt_err0          pairs with a nonzero error
//   cnt_err1          pairs whose [DATA_W-1:ER_THRESH] fields differ
//   sum_err           signed sum of (appr - accu)
//   sum_abs_accu      sum of |accu|
//   max_abs_err       largest |appr - accu| (FIR_ERR_MONITOR_MAX_ERR_EN only)
//
// Optional build macro: FIR_ERR_MONITOR_MAX_ERR_EN adds max_abs_err.
//
// Timing: a pair accepted at edge k is registered into stage 1 at k, moves to
// stage 2 at k+1 and is folded into the statistics at k+2. The run finishes
// on the edge that retires the last stage-2 entry, so done rises two cycles
// after the final accepted pair.

module fir_err_monitor #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned ER_THRESH = 8,
  parameter int unsigned ACC_W     = DATA_W + CNT_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    start,
  input  logic [CNT_W-1:0]        n_samples,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       appr,
  input  logic [DATA_W-1:0]       accu,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        cnt_err0,
  output logic [CNT_W-1:0]        cnt_err1,
  output logic signed [ACC_W-1:0] sum_err,
  output logic [ACC_W-1:0]        sum_abs_accu
`ifdef FIR_ERR_MONITOR_MAX_ERR_EN
  ,
  output logic [DATA_W:0]         max_abs_err
`endif
);

  // Error width: one extra bit so appr - accu and |most-negative| are exact.
  localparam int unsigned EW = DATA_W + 1;
  localparam int unsigned XW = ACC_W - EW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_d;
  logic             in_ready_d, busy_d, done_d;
  logic             start_acc, accept;

  logic [CNT_W-1:0] n_cap;
  logic [CNT_W-1:0] acc_cnt;

  // Stage-1 combinational terms from the live input pair
  logic [EW-1:0]    appr_x, accu_x;
  logic [EW-1:0]    err_c;
  logic [EW-1:0]    abs_accu_c;
  logic             f0_c, f1_c;

  // Stage 1 registers
  logic             s1_v;
  logic [EW-1:0]    s1_err;
  logic [EW-1:0]    s1_abs_accu;
  logic             s1_f0, s1_f1;

  // Stage 2 registers
  logic             s2_v;
  logic [EW-1:0]    s2_err;
  logic [EW-1:0]    s2_abs_accu;
  logic             s2_f0, s2_f1;

`ifdef FIR_ERR_MONITOR_MAX_ERR_EN
  logic [EW-1:0]    abs_err_c;
  logic [EW-1:0]    s1_abs_err;
  logic [EW-1:0]    s2_abs_err;
`endif

  // Next-state, handshake and registered-output decode
  always_comb begin
    state_d    = state;
    start_acc  = 1'b0;
    accept     = 1'b0;
    in_ready_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = (n_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_valid && in_ready) begin
          accept = 1'b1;
          if (acc_cnt == n_cap - CNT_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Stage 1 empty means the last entry sits in stage 2 and retires now.
        if (!s1_v) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d   = IDLE;
      start_acc = 1'b0;
      accept    = 1'b0;
    end

    in_ready_d = (state_d == RUN);
    busy_d     = (state_d == RUN) || (state_d == DRAIN);
    done_d     = (state_d == DONE);
  end

  // State register and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      in_ready <= in_ready_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Run length capture and accepted-pair counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_cap   <= '0;
      acc_cnt <= '0;
    end else if (clear) begin
      n_cap   <= '0;
      acc_cnt <= '0;
    end else if (start_acc) begin
      n_cap   <= n_samples;
      acc_cnt <= '0;
    end else if (accept) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

  // Sign-extended error and magnitudes; negation never overflows at EW bits
  always_comb begin
    appr_x     = {appr[DATA_W-1], appr};
    accu_x     = {accu[DATA_W-1], accu};
    err_c      = appr_x - accu_x;
    abs_accu_c = accu_x[EW-1] ? (EW'(0) - accu_x) : accu_x;
    f0_c       = (err_c != '0);
    f1_c       = (appr[DATA_W-1:ER_THRESH] != accu[DATA_W-1:ER_THRESH]);
  end

`ifdef FIR_ERR_MONITOR_MAX_ERR_EN
  assign abs_err_c = err_c[EW-1] ? (EW'(0) - err_c) : err_c;
`endif

  // Stage 1: capture the accepted pair's derived terms
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v        <= 1'b0;
      s1_err      <= '0;
      s1_abs_accu <= '0;
      s1_f0       <= 1'b0;
      s1_f1       <= 1'b0;
    end else if (clear) begin
      s1_v        <= 1'b0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_err      <= err_c;
        s1_abs_accu <= abs_accu_c;
        s1_f0       <= f0_c;
        s1_f1       <= f1_c;
      end
    end
  end

  // Stage 2: operand register feeding the accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v        <= 1'b0;
      s2_err      <= '0;
      s2_abs_accu <= '0;
      s2_f0       <= 1'b0;
      s2_f1       <= 1'b0;
    end else if (clear) begin
      s2_v        <= 1'b0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_err      <= s1_err;
        s2_abs_accu <= s1_abs_accu;
        s2_f0       <= s1_f0;
        s2_f1       <= s1_f1;
      end
    end
  end

`ifdef FIR_ERR_MONITOR_MAX_ERR_EN
  // Magnitude of the error travels alongside the other stage terms
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_abs_err <= '0;
      s2_abs_err <= '0;
    end else begin
      if (accept) begin
        s1_abs_err <= abs_err_c;
      end
      if (s1_v) begin
        s2_abs_err <= s1_abs_err;
      end
    end
  end
`endif

  // Statistics: zeroed by clear or an accepted start, updated only by a
  // valid stage-2 entry, otherwise held (including throughout DONE)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_err0     <= '0;
      cnt_err1     <= '0;
      sum_err      <= '0;
      sum_abs_accu <= '0;
    end else if (clear || start_acc) begin
      cnt_err0     <= '0;
      cnt_err1     <= '0;
      sum_err      <= '0;
      sum_abs_accu <= '0;
    end else if (s2_v) begin
      cnt_err0     <= cnt_err0 + CNT_W'(s2_f0);
      cnt_err1     <= cnt_err1 + CNT_W'(s2_f1);
      sum_err      <= sum_err + $signed({{XW{s2_err[EW-1]}}, s2_err});
      sum_abs_accu <= sum_abs_accu + {{XW{1'b0}}, s2_abs_accu};
    end
  end

`ifdef FIR_ERR_MONITOR_MAX_ERR_EN
  // Running maximum of |error|
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_abs_err <= '0;
    end else if (clear || start_acc) begin
      max_abs_err <= '0;
    end else if (s2_v && (s2_abs_err > max_abs_err)) begin
      max_abs_err <= s2_abs_err;
    end
  end
`endif

endmodule

// File: tb/tb_fir_err_monitor.sv
// Testbench for fir_err_monitor: directed scenarios plus randomized runs
// compared against a plain-arithmetic reference model over the pair list.
module tb_fir_err_monitor;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned ER_THRESH = 8;
  localparam int unsigned ACC_W     = DATA_W + CNT_W + 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    clear;
  logic                    start;
  logic [CNT_W-1:0]        n_samples;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       appr;
  logic [DATA_W-1:0]       accu;
  logic                    busy;
  logic                    done;
  logic [CNT_W-1:0]        cnt_err0;
  logic [CNT_W-1:0]        cnt_err1;
  logic signed [ACC_W-1:0] sum_err;
  logic [ACC_W-1:0]        sum_abs_accu;
`ifdef FIR_ERR_MONITOR_MAX_ERR_EN
  logic [DATA_W:0]         max_abs_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic signed [31:0] qa [0:63];
  logic signed [31:0] qb [0:63];

  always #5 clk = ~clk;

  fir_err_monitor #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .ER_THRESH(ER_THRESH), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .appr(appr), .accu(accu),
    .busy(busy), .done(done), .cnt_err0(cnt_err0), .cnt_err1(cnt_err1),
    .sum_err(sum_err), .sum_abs_accu(sum_abs_accu)
`ifdef FIR_ERR_MONITOR_MAX_ERR_EN
    , .max_abs_err(max_abs_err)
`endif
  );

  // Reference statistics over the first n pairs of qa/qb
  function automatic void model(input int n, output longint c0, output longint c1,
                                output longint se, output longint sa, output longint mx);
    longint e, ae;
    c0 = 0; c1 = 0; se = 0; sa = 0; mx = 0;
    for (int i = 0; i < n; i++) begin
      e = longint'(qa[i]) - longint'(qb[i]);
      ae = (e < 0) ? -e : e;
      if (e != 0) c0++;
      if ((qa[i] >>> ER_THRESH) != (qb[i] >>> ER_THRESH)) c1++;
      se += e;
      sa += (qb[i] < 0) ? -longint'(qb[i]) : longint'(qb[i]);
      if (ae > mx) mx = ae;
    end
  endfunction

  task automatic fill(input int n);
    int t, d;
    for (int i = 0; i < n; i++) begin
      t = int'($urandom_range(0, 4000)) - 2000;
      d = int'($urandom_range(0, 600)) - 300;
      case ($urandom_range(0, 3))
        0: begin qa[i] = $urandom; qb[i] = $urandom; end
        1: begin qa[i] = t; qb[i] = t; end
        2: begin qa[i] = t + d; qb[i] = t; end
        default: begin
          qa[i] = $urandom_range(0, 1) ? 32'h7FFFFFFF : 32'h80000000;
          qb[i] = $urandom_range(0, 1) ? 32'h80000000 : t;
        end
      endcase
    end
  endtask

  // Runs one measurement: mode 0 always valid, 1 valid pattern 1,0,0,1,0,1,
  // 2 random valid. restart_at >= 0 pulses start after that many accepts.
  // lat = edges from last accept (or the start edge) until done is seen.
  task automatic run_pairs(input int n, input int mode, input int restart_at,
                           output int lat, output bit hs_ok, output bit zero_ok);
    int  idx, edge_cnt, last_edge;
    bit  exp_rdy, v, pulsed;
    hs_ok = 1'b1; lat = -1; pulsed = 1'b0; idx = 0;
    start = 1'b1; n_samples = CNT_W'(n); in_valid = 1'b0;
    @(posedge clk);
    edge_cnt = 1; last_edge = 1;
    #1;
    start = 1'b0;
    zero_ok = (cnt_err0 == '0) && (cnt_err1 == '0) && (sum_err == '0) && (sum_abs_accu == '0);
`ifdef FIR_ERR_MONITOR_MAX_ERR_EN
    if (max_abs_err != '0) zero_ok = 1'b0;
`endif
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (done === 1'b1) begin
        lat = edge_cnt - last_edge;
        if (in_ready !== 1'b0 || busy !== 1'b0) hs_ok = 1'b0;
        break;
      end
      exp_rdy = (idx < n);
      if (in_ready !== exp_rdy) hs_ok = 1'b0;
      if (exp_rdy && busy !== 1'b1) hs_ok = 1'b0;
      case (mode)
        0: v = 1'b1;
        1: v = ((cyc % 6) == 0) || ((cyc % 6) == 3) || ((cyc % 6) == 5);
        default: v = 1'(($urandom_range(0, 1)));
      endcase
      appr = exp_rdy ? qa[idx] : $urandom;
      accu = exp_rdy ? qb[idx] : $urandom;
      in_valid = v;
      if (idx == restart_at && exp_rdy && !pulsed) begin
        start = 1'b1; n_samples = CNT_W'(1); pulsed = 1'b1;
      end
      @(posedge clk);
      edge_cnt++;
      if (v && exp_rdy) begin idx++; last_edge = edge_cnt; end
      #1;
      start = 1'b0; n_samples = CNT_W'(n);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; start = 1'b0; n_samples = '0;
    in_valid = 1'b1; appr = 32'h1234; accu = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({in_ready, busy, done} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {in_ready, busy, done});
    else n_pass++;
    n_checks++;
    if (cnt_err0 !== '0 || cnt_err1 !== '0) $display("FAIL reset_counts: got %0d/%0d want 0/0", cnt_err0, cnt_err1);
    else n_pass++;
    n_checks++;
    if (sum_err !== '0 || sum_abs_accu !== '0) $display("FAIL reset_sums: got %0d/%0d want 0/0", sum_err, sum_abs_accu);
    else n_pass++;
`ifdef FIR_ERR_MONITOR_MAX_ERR_EN
    n_checks++;
    if (max_abs_err !== '0) $display("FAIL reset_max: got %0d want 0", max_abs_err);
    else n_pass++;
`endif
  endtask

  task automatic test_directed();
    int lat; bit hs, z;
    qa[0] = 100;  qb[0] = 100;
    qa[1] = 105;  qb[1] = 100;
    qa[2] = 356;  qb[2] = 100;
    qa[3] = -50;  qb[3] = -40;
    run_pairs(4, 0, -1, lat, hs, z);
    n_checks++;
    if (lat !== 2) $display("FAIL directed_latency: got %0d want 2", lat); else n_pass++;
    n_checks++;
    if (!hs) $display("FAIL directed_handshake: got 0 want 1"); else n_pass++;
    n_checks++;
    if (cnt_err0 !== 32'd3 || cnt_err1 !== 32'd1)
      $display("FAIL directed_counts: got %0d/%0d want 3/1", cnt_err0, cnt_err1);
    else n_pass++;
    n_checks++;
    if (sum_err !== 65'sd251) $display("FAIL directed_sum_err: got %0d want 251", sum_err); else n_pass++;
    n_checks++;
    if (sum_abs_accu !== 65'd340) $display("FAIL directed_sum_abs: got %0d want 340", sum_abs_accu); else n_pass++;
`ifdef FIR_ERR_MONITOR_MAX_ERR_EN
    n_checks++;
    if (max_abs_err !== 33'd256) $display("FAIL directed_max: got %0d want 256", max_abs_err); else n_pass++;
`endif
    // Extra valid traffic in DONE must not disturb the held results
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; appr = $urandom; accu = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (done !== 1'b1 || sum_err !== 65'sd251 || cnt_err0 !== 32'd3)
      $display("FAIL directed_hold: got done=%0b sum=%0d cnt0=%0d want 1/251/3", done, sum_err, cnt_err0);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    int lat; bit hs, z;
    run_pairs(0, 0, -1, lat, hs, z);
    n_checks++;
    if (lat !== 0) $display("FAIL zero_len_latency: got %0d want 0", lat); else n_pass++;
    n_checks++;
    if (!z || sum_err !== '0 || cnt_err0 !== '0)
      $display("FAIL zero_len_stats: got zero=%0b sum=%0d want 1/0", z, sum_err);
    else n_pass++;
    n_checks++;
    if (!hs) $display("FAIL zero_len_ready: got 0 want 1"); else n_pass++;
  endtask

  task automatic test_gaps();
    int lat; bit hs, z;
    logic [CNT_W-1:0] b0, b1; logic signed [ACC_W-1:0] bs; logic [ACC_W-1:0] ba;
    fill(3);
    run_pairs(3, 0, -1, lat, hs, z);
    b0 = cnt_err0; b1 = cnt_err1; bs = sum_err; ba = sum_abs_accu;
    run_pairs(3, 1, -1, lat, hs, z);
    n_checks++;
    if (lat !== 2 || !hs) $display("FAIL gaps_timing: got lat=%0d hs=%0b want 2/1", lat, hs); else n_pass++;
    n_checks++;
    if (cnt_err0 !== b0 || cnt_err1 !== b1 || sum_err !== bs || sum_abs_accu !== ba)
      $display("FAIL gaps_vs_b2b: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               cnt_err0, cnt_err1, sum_err, sum_abs_accu, b0, b1, bs, ba);
    else n_pass++;
  endtask

  task automatic test_extreme();
    int lat; bit hs, z;
    qa[0] = 32'h7FFFFFFF; qb[0] = 32'h80000000;
    run_pairs(1, 0, -1, lat, hs, z);
    n_checks++;
    if (sum_err !== 65'sd4294967295) $display("FAIL extreme_sum_err: got %0d want 4294967295", sum_err); else n_pass++;
    n_checks++;
    if (sum_abs_accu !== 65'd2147483648) $display("FAIL extreme_sum_abs: got %0d want 2147483648", sum_abs_accu); else n_pass++;
    n_checks++;
    if (cnt_err1 !== 32'd1 || cnt_err0 !== 32'd1) $display("FAIL extreme_counts: got %0d/%0d want 1/1", cnt_err0, cnt_err1); else n_pass++;
`ifdef FIR_ERR_MONITOR_MAX_ERR_EN
    n_checks++;
    if (max_abs_err !== 33'd4294967295) $display("FAIL extreme_max: got %0d want 4294967295", max_abs_err); else n_pass++;
`endif
  endtask

  task automatic test_clear();
    int lat; bit hs, z;
    start = 1'b1; n_samples = CNT_W'(5);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; appr = 32'd10; accu = 32'd3;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_checks++;
    if ({in_ready, busy, done} !== 3'b000 || cnt_err0 !== '0 || sum_err !== '0 || sum_abs_accu !== '0)
      $display("FAIL clear_idle: got flags=%b cnt0=%0d sum=%0d want 000/0/0", {in_ready, busy, done}, cnt_err0, sum_err);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (cnt_err0 !== '0 || sum_err !== '0 || sum_abs_accu !== '0)
      $display("FAIL clear_inflight: got cnt0=%0d sum=%0d want 0/0", cnt_err0, sum_err);
    else n_pass++;
    qa[0] = 7; qb[0] = 7;
    run_pairs(1, 0, -1, lat, hs, z);
    n_checks++;
    if (done !== 1'b1 || cnt_err0 !== '0 || lat !== 2)
      $display("FAIL clear_rerun: got done=%0b cnt0=%0d lat=%0d want 1/0/2", done, cnt_err0, lat);
    else n_pass++;
  endtask

  task automatic test_restart();
    int lat; bit hs, z;
    longint c0, c1, se, sa, mx;
    fill(4);
    model(4, c0, c1, se, sa, mx);
    run_pairs(4, 0, 1, lat, hs, z);
    n_checks++;
    if (lat !== 2 || !hs) $display("FAIL restart_ignored_timing: got lat=%0d hs=%0b want 2/1", lat, hs); else n_pass++;
    n_checks++;
    if (sum_err !== 65'(se) || cnt_err0 !== 32'(c0))
      $display("FAIL restart_ignored_stats: got %0d/%0d want %0d/%0d", sum_err, cnt_err0, se, c0);
    else n_pass++;
    fill(3);
    model(3, c0, c1, se, sa, mx);
    run_pairs(3, 2, -1, lat, hs, z);
    n_checks++;
    if (!z) $display("FAIL restart_from_done_zero: got 0 want 1"); else n_pass++;
    n_checks++;
    if (sum_err !== 65'(se) || sum_abs_accu !== 65'(sa) || cnt_err1 !== 32'(c1))
      $display("FAIL restart_from_done_stats: got %0d/%0d/%0d want %0d/%0d/%0d",
               sum_err, sum_abs_accu, cnt_err1, se, sa, c1);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat, n; bit hs, z;
    longint c0, c1, se, sa, mx;
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 12));
      fill(n);
      model(n, c0, c1, se, sa, mx);
      run_pairs(n, 2, -1, lat, hs, z);
      n_checks++;
      if (lat !== 2 || !hs || !z) $display("FAIL random%0d_ctrl: got lat=%0d hs=%0b z=%0b want 2/1/1", r, lat, hs, z);
      else n_pass++;
      n_checks++;
      if (cnt_err0 !== 32'(c0) || cnt_err1 !== 32'(c1))
        $display("FAIL random%0d_counts: got %0d/%0d want %0d/%0d", r, cnt_err0, cnt_err1, c0, c1);
      else n_pass++;
      n_checks++;
      if (sum_err !== 65'(se) || sum_abs_accu !== 65'(sa))
        $display("FAIL random%0d_sums: got %0d/%0d want %0d/%0d", r, sum_err, sum_abs_accu, se, sa);
      else n_pass++;
`ifdef FIR_ERR_MONITOR_MAX_ERR_EN
      n_checks++;
      if (max_abs_err !== 33'(mx)) $display("FAIL random%0d_max: got %0d want %0d", r, max_abs_err, mx);
      else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_len();
    test_gaps();
    test_extreme();
    test_clear();
    test_restart();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
